avmm_led_sequencer: RTL and testbench
=====================================

AVMM_LED_SEQUENCER -- requirements
Module: avmm_led_sequencer

Interface
REQ-001 Parameter DEFAULT_PERIOD, 24'd12_500_000, reset value of the PERIOD register in clk cycles per step.
REQ-002 Parameter SYNC_STAGES, 2, number of flip-flops synchronising the mode input.
REQ-003 clk  in  1  single system clock.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 avs_address  in  2  Avalon-MM slave word address.
REQ-006 avs_read  in  1  read strobe.
REQ-007 avs_write  in  1  write strobe.
REQ-008 avs_writedata  in  32  write data.
REQ-009 avs_readdata  out  32  read data, fixed read latency of 1 cycle, no waitrequest.
REQ-010 mode  in  2  asynchronous board switch input.
REQ-011 q  out  8  LED drive, registered.

Function
REQ-012 Register map: 0 CTRL (RW), 1 PATTERN (RW), 2 PERIOD (RW), 3 STATUS (RO; a write clears STEPS).
REQ-013 CTRL fields: bit0 EN; bits2:1 SEL (00 static, 01 rotate-left, 10 rotate-right, 11 blink); bit3 EXT (1 = SEL is taken from synchronised mode); bits31:4 read 0.
REQ-014 PATTERN holds 8 bits in 7:0; PERIOD holds 24 bits in 23:0; unused bits read 0 and ignore writes.
REQ-015 STATUS: bits1:0 synchronised mode; bit2 RUN (state == RUN); bits15:8 STEPS, an 8-bit step counter that wraps 255->0.
REQ-016 A read with address A in cycle N shall drive readdata for A in cycle N+1; readdata is 0 when no read is pending.
REQ-017 Simultaneous read and write to the same address shall return the value held before the write.
REQ-018 The FSM has two states, IDLE and RUN; IDLE->RUN when EN=1; RUN->IDLE when EN=0, effective the cycle after the CTRL write.
REQ-019 In IDLE, q shall equal PATTERN, the prescaler shall be held at 0, and the shift register shall be loaded from PATTERN.
REQ-020 In RUN, the prescaler shall count 0..max(PERIOD,1)-1; a step tick occurs on the wrap cycle.
REQ-021 On a tick, the effective mode shall act as follows: 00 q unchanged; 01 q rotates left by 1; 10 q rotates right by 1; 11 q toggles between PATTERN and 8'h00. STEPS increments on every tick.
REQ-022 The effective mode is SEL when EXT=0, else synchronised mode; a change of effective mode takes effect at the next tick without reloading q.
REQ-023 A PATTERN write in RUN shall load q and the shift register with the new value the next cycle, and shall reset the prescaler to 0; if a tick coincides with the write, the write wins and the tick is discarded.
REQ-024 A PERIOD write shall reset the prescaler to 0; PERIOD=0 behaves as 1, giving a tick every cycle.
REQ-025 A STATUS write coinciding with a tick shall leave STEPS at 0.
REQ-026 mode shall pass through SYNC_STAGES flip-flops before any use; its latency to STATUS is SYNC_STAGES cycles.

Reset
REQ-027 Reset values: CTRL=0, PATTERN=8'h01, PERIOD=DEFAULT_PERIOD, STEPS=0, prescaler=0, state=IDLE, q=8'h01, readdata=0, synchroniser=0.
REQ-028 Reset mid-run shall return all state to the REQ-027 values immediately (asynchronously); normal operation resumes on the first clk edge after deassertion.

Structure
REQ-029 Package led_seq_pkg shall hold the register address constants, CTRL bit positions, the SEL mode enum, and the FSM state enum.
REQ-030 One sub-module, led_seq_sync, shall implement the SYNC_STAGES-deep 2-bit synchroniser; the register file and the FSM stay in the top module.

Verification
REQ-031 Reset release, then read addresses 0..3 -> readdata one cycle later: 0, 0x01, DEFAULT_PERIOD, {mode,0 RUN,0 STEPS}; q=0x01.
REQ-032 PERIOD=4, PATTERN=0x81, CTRL=0x3 (EN, rotate-left) -> q: 0x03 after 4 cycles, 0x06 after 8; STEPS=2.
REQ-033 PERIOD=0, CTRL=0x7 (blink) -> q alternates 0x01/0x00 every cycle; after 300 ticks STEPS=44 (wrapped).
REQ-034 CTRL=0x9 (EN, EXT), mode=2'b10 -> after 2 sync cycles plus one tick, q rotates right: 0x01->0x80.
REQ-035 PATTERN write of 0x55 on the same cycle as a tick -> q=0x55 next cycle with no rotation; the next tick comes PERIOD cycles later.
REQ-036 reset_n pulsed low mid-RUN with q=0x10 -> q=0x01, RUN=0, and CTRL=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/led_seq_pkg.sv
// Shared definitions for the Avalon-MM LED sequencer: register map, CTRL
// field positions, step modes, FSM states and the per-tick LED step function.
package led_seq_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_SEL_LSB = 1;
  localparam int CTRL_SEL_MSB = 2;
  localparam int CTRL_EXT_BIT = 3;
  localparam int CTRL_W       = 4;

  typedef enum logic [1:0] {
    SEL_STATIC = 2'b00,
    SEL_ROL    = 2'b01,
    SEL_ROR    = 2'b10,
    SEL_BLINK  = 2'b11
  } sel_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Blink alternates between the pattern and dark; any non-dark value goes dark first.
  function automatic logic [7:0] step_led(input sel_mode_e m, input logic [7:0] cur,
                                          input logic [7:0] pat);
    logic [7:0] nxt;
    nxt = cur;
    case (m)
      SEL_STATIC: nxt = cur;
      SEL_ROL:    nxt = {cur[6:0], cur[7]};
      SEL_ROR:    nxt = {cur[0], cur[7:1]};
      SEL_BLINK:  nxt = (cur != 8'h00) ? 8'h00 : pat;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/led_seq_sync.sv
// Multi-stage flip-flop synchroniser for a slow asynchronous bus (board switches).
module led_seq_sync #(
  parameter int STAGES = 2,
  parameter int W      = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] async_i,
  output logic [W-1:0] sync_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/avmm_led_sequencer.sv
// Avalon-MM controlled LED sequencer: register file, IDLE/RUN FSM, step
// prescaler and LED shift register; the mode switches go through led_seq_sync.
module avmm_led_sequencer
  import led_seq_pkg::*;
#(
  parameter logic [23:0] DEFAULT_PERIOD = 24'd12_500_000,
  parameter int          SYNC_STAGES    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic [1:0]  mode,
  output logic [7:0]  q
);

  // Bus handshake: no waitrequest; a write strobe is accepted on the edge it is
  // seen, and a read strobe in cycle N returns data in cycle N+1 (0 otherwise).

  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [7:0]        pattern_q, pattern_d;
  logic [23:0]       period_q,  period_d;
  logic [7:0]        steps_q,   steps_d;
  logic [23:0]       presc_q,   presc_d;
  logic [7:0]        led_q,     led_d;
  logic [31:0]       rdata_q,   rdata_d;
  state_e            state_q,   state_d;

  logic [1:0]  mode_sync;
  sel_mode_e   eff_mode;
  logic [23:0] presc_max;
  logic        tick, tick_eff, run;
  logic        wr_ctrl, wr_pattern, wr_period, wr_status;
  logic [31:0] status_word;
  logic        unused_wdata;

  led_seq_sync #(
    .STAGES (SYNC_STAGES),
    .W      (2)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (mode),
    .sync_o  (mode_sync)
  );

  assign wr_ctrl    = avs_write && (avs_address == ADDR_CTRL);
  assign wr_pattern = avs_write && (avs_address == ADDR_PATTERN);
  assign wr_period  = avs_write && (avs_address == ADDR_PERIOD);
  assign wr_status  = avs_write && (avs_address == ADDR_STATUS);

  assign run       = (state_q == ST_RUN);
  assign eff_mode  = sel_mode_e'(ctrl_q[CTRL_EXT_BIT] ? mode_sync
                                                      : ctrl_q[CTRL_SEL_MSB:CTRL_SEL_LSB]);
  // PERIOD of 0 is treated as 1, so the prescaler wraps every cycle.
  assign presc_max = (period_q == 24'd0) ? 24'd0 : period_q - 24'd1;
  assign tick      = run && (presc_q == presc_max);
  assign tick_eff  = tick && !wr_pattern;

  assign status_word  = {16'h0000, steps_q, 5'b00000, run, mode_sync};
  assign unused_wdata = ^avs_writedata[31:24];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (ctrl_q[CTRL_EN_BIT])  state_d = ST_RUN;
      ST_RUN:  if (!ctrl_q[CTRL_EN_BIT]) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    pattern_d = pattern_q;
    period_d  = period_q;
    steps_d   = steps_q;
    presc_d   = presc_q;
    led_d     = led_q;
    rdata_d   = 32'h0;

    if (wr_ctrl)    ctrl_d    = avs_writedata[CTRL_W-1:0];
    if (wr_pattern) pattern_d = avs_writedata[7:0];
    if (wr_period)  period_d  = avs_writedata[23:0];

    if (!run || tick || wr_pattern || wr_period) presc_d = 24'd0;
    else                                         presc_d = presc_q + 24'd1;

    // A pattern write always wins over a coincident tick.
    if (wr_pattern)  led_d = avs_writedata[7:0];
    else if (!run)   led_d = pattern_q;
    else if (tick)   led_d = step_led(eff_mode, led_q, pattern_q);

    if (wr_status)     steps_d = 8'd0;
    else if (tick_eff) steps_d = steps_q + 8'd1;

    if (avs_read) begin
      case (avs_address)
        ADDR_CTRL:    rdata_d = {{(32-CTRL_W){1'b0}}, ctrl_q};
        ADDR_PATTERN: rdata_d = {24'h000000, pattern_q};
        ADDR_PERIOD:  rdata_d = {8'h00, period_q};
        ADDR_STATUS:  rdata_d = status_word;
        default:      rdata_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      pattern_q <= 8'h01;
      period_q  <= DEFAULT_PERIOD;
      steps_q   <= 8'd0;
      presc_q   <= 24'd0;
      led_q     <= 8'h01;
      rdata_q   <= 32'h0;
    end else begin
      ctrl_q    <= ctrl_d;
      pattern_q <= pattern_d;
      period_q  <= period_d;
      steps_q   <= steps_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
      rdata_q   <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign q            = led_q;

endmodule

// File: tb/tb_avmm_led_sequencer.sv
// Directed bench for avmm_led_sequencer: register access, stepping modes,
// tick/write collisions, mode synchronisation and asynchronous reset.
module tb_avmm_led_sequencer;

  localparam logic [31:0] DEF_PERIOD = 32'd12_500_000;
  localparam logic [1:0]  A_CTRL = 2'd0, A_PAT = 2'd1, A_PER = 2'd2, A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  q;

  int tests_run = 0;
  int tests_failed = 0;

  avmm_led_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .mode          (mode),
    .q             (q)
  );

  always #5 clk = ~clk;

  // ---- driver tasks: all return 1 time unit after the edge they used ----
  task automatic do_reset();
    reset_n = 1'b0;
    avs_read = 1'b0;
    avs_write = 1'b0;
    mode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a;
    avs_writedata = d;
    avs_write = 1'b1;
    @(posedge clk);
    #1;
    avs_write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic bus_rw(input logic [1:0] a, input logic [31:0] wd, output logic [31:0] rd);
    avs_address = a;
    avs_writedata = wd;
    avs_read = 1'b1;
    avs_write = 1'b1;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    avs_write = 1'b0;
    rd = avs_readdata;
  endtask

  // ---- tests ----
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL reset_q: got %h expected 01", q); end
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected 0", d); end
    bus_read(A_PAT, d);
    tests_run++;
    if (d !== 32'h1) begin tests_failed++; $display("FAIL reset_pattern: got %h expected 1", d); end
    bus_read(A_PER, d);
    tests_run++;
    if (d !== DEF_PERIOD) begin tests_failed++; $display("FAIL reset_period: got %h expected %h", d, DEF_PERIOD); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected 0", d); end
    @(posedge clk);
    #1;
    tests_run++;
    if (avs_readdata !== 32'h0) begin tests_failed++; $display("FAIL idle_readdata: got %h expected 0", avs_readdata); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    do_reset();
    bus_write(A_CTRL, 32'hFFFF_FFF0);
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL ctrl_unused: got %h expected 0", d); end
    bus_write(A_PAT, 32'hFFFF_FF3C);
    bus_read(A_PAT, d);
    tests_run++;
    if (d !== 32'h3C) begin tests_failed++; $display("FAIL pattern_mask: got %h expected 3c", d); end
    tests_run++;
    if (q !== 8'h3C) begin tests_failed++; $display("FAIL idle_q_pattern: got %h expected 3c", q); end
    bus_write(A_PER, 32'hFFFF_FFFF);
    bus_read(A_PER, d);
    tests_run++;
    if (d !== 32'h00FF_FFFF) begin tests_failed++; $display("FAIL period_mask: got %h expected 00ffffff", d); end
    bus_rw(A_PAT, 32'hA5, d);
    tests_run++;
    if (d !== 32'h3C) begin tests_failed++; $display("FAIL rw_old_value: got %h expected 3c", d); end
    bus_read(A_PAT, d);
    tests_run++;
    if (d !== 32'hA5) begin tests_failed++; $display("FAIL rw_new_value: got %h expected a5", d); end
  endtask

  task automatic test_rotate();
    logic [31:0] d;
    do_reset();
    bus_write(A_PER, 32'd4);
    bus_write(A_PAT, 32'h81);
    bus_write(A_CTRL, 32'h3);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h81) begin tests_failed++; $display("FAIL rol_before_tick: got %h expected 81", q); end
    @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h03) begin tests_failed++; $display("FAIL rol_step1: got %h expected 03", q); end
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h06) begin tests_failed++; $display("FAIL rol_step2: got %h expected 06", q); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_0204) begin tests_failed++; $display("FAIL rol_status: got %h expected 00000204", d); end
    bus_write(A_STAT, 32'h0);
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_0004) begin tests_failed++; $display("FAIL steps_clear: got %h expected 00000004", d); end
  endtask

  task automatic test_blink();
    logic [31:0] d;
    do_reset();
    bus_write(A_PER, 32'd0);
    bus_write(A_CTRL, 32'h7);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (q !== ((i % 2 == 0) ? 8'h01 : 8'h00)) begin
        tests_failed++;
        $display("FAIL blink_cycle%0d: got %h expected %h", i, q, (i % 2 == 0) ? 8'h01 : 8'h00);
      end
    end
    repeat (297) @(posedge clk);
    #1;
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_2C04) begin tests_failed++; $display("FAIL steps_wrap: got %h expected 00002c04", d); end
    bus_write(A_STAT, 32'h0);
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_0004) begin tests_failed++; $display("FAIL clear_on_tick: got %h expected 00000004", d); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_0104) begin tests_failed++; $display("FAIL count_after_clear: got %h expected 00000104", d); end
  endtask

  task automatic test_sync();
    logic [31:0] d;
    do_reset();
    mode = 2'b11;
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL sync_early1: got %h expected 0", d); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL sync_early2: got %h expected 0", d); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h3) begin tests_failed++; $display("FAIL sync_settled: got %h expected 3", d); end
    mode = 2'b00;
  endtask

  task automatic test_ext_mode();
    do_reset();
    mode = 2'b10;
    bus_write(A_PER, 32'd4);
    bus_write(A_CTRL, 32'h9);
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL ext_before_tick: got %h expected 01", q); end
    @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h80) begin tests_failed++; $display("FAIL ext_ror: got %h expected 80", q); end
    mode = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h80) begin tests_failed++; $display("FAIL ext_to_static: got %h expected 80", q); end
  endtask

  task automatic test_pattern_tick();
    logic [31:0] d;
    do_reset();
    bus_write(A_PER, 32'd4);
    bus_write(A_PAT, 32'h81);
    bus_write(A_CTRL, 32'h3);
    repeat (4) @(posedge clk);
    #1;
    bus_write(A_PAT, 32'h55);
    tests_run++;
    if (q !== 8'h55) begin tests_failed++; $display("FAIL pat_wins: got %h expected 55", q); end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h55) begin tests_failed++; $display("FAIL pat_hold: got %h expected 55", q); end
    @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'hAA) begin tests_failed++; $display("FAIL pat_next_tick: got %h expected aa", q); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0000_0104) begin tests_failed++; $display("FAIL pat_tick_dropped: got %h expected 00000104", d); end
  endtask

  task automatic test_period_write();
    do_reset();
    bus_write(A_PER, 32'd4);
    bus_write(A_CTRL, 32'h3);
    repeat (2) @(posedge clk);
    #1;
    bus_write(A_PER, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL per_presc_reset: got %h expected 01", q); end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h02) begin tests_failed++; $display("FAIL per_late_tick: got %h expected 02", q); end
  endtask

  task automatic test_reset_mid_run();
    logic [31:0] d;
    do_reset();
    bus_write(A_PER, 32'd4);
    bus_write(A_PAT, 32'h10);
    bus_write(A_CTRL, 32'h1);
    repeat (6) @(posedge clk);
    #1;
    tests_run++;
    if (q !== 8'h10) begin tests_failed++; $display("FAIL static_hold: got %h expected 10", q); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL async_reset_q: got %h expected 01", q); end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus_read(A_CTRL, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL async_reset_ctrl: got %h expected 0", d); end
    bus_read(A_STAT, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL async_reset_status: got %h expected 0", d); end
    tests_run++;
    if (q !== 8'h01) begin tests_failed++; $display("FAIL post_reset_q: got %h expected 01", q); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_rotate();
    test_blink();
    test_sync();
    test_ext_mode();
    test_pattern_tick();
    test_period_write();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
